// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO and sequencer feeding the UART byte transmitter one byte per tx_done handshake.
// Optional inter-frame idle gap enabled by defining UART_TX_FEED_GAP_EN.
module uart_tx_fifo_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              wr_overflow,
    output logic [7:0]        tx_data_byte,
    output logic              tx_send_en,
    input  logic              tx_done,
    output logic              feeder_busy
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);

    generate
        if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || GAP_CYCLES < 1) begin : g_bad_cfg
            $error("uart_tx_fifo_feeder: DEPTH must be 2**ADDR_W (>=2) and GAP_CYCLES >= 1");
        end
    endgenerate

`ifdef UART_TX_FEED_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              pop, wr_acc, send_nxt;
    logic [ADDR_W:0]   level_nxt;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts that write.
    assign pop    = (state == IDLE) && !empty;
    assign wr_acc = wr_en && (!full || pop);

    always_comb begin
        level_nxt = level;
        if (wr_acc && !pop)
            level_nxt = level + LVL_ONE;
        else if (!wr_acc && pop)
            level_nxt = level - LVL_ONE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty) state_nxt = SEND;
            SEND:      state_nxt = WAIT_DONE;
`ifdef UART_TX_FEED_GAP_EN
            WAIT_DONE: if (tx_done) state_nxt = GAP;
            GAP:       if (gap_cnt == GAP_LAST) state_nxt = IDLE;
`else
            WAIT_DONE: if (tx_done) state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
        send_nxt = (state_nxt == SEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            wr_overflow  <= 1'b0;
            tx_data_byte <= 8'h00;
            tx_send_en   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tx_send_en  <= send_nxt;
            wr_overflow <= wr_en && !wr_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr       <= rd_ptr + ADDR_W'(1);
                tx_data_byte <= mem[rd_ptr];
            end
            // Flags come from the next level so they never lag it.
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            empty <= (level_nxt == '0);
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

`ifdef UART_TX_FEED_GAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if (state != GAP)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + GAP_W'(1);
    end
`endif

    assign feeder_busy = (state != IDLE) || !empty;

`ifndef SYNTHESIS
    a_send_one_cycle: assert property (@(posedge clk) disable iff (reset)
        tx_send_en |=> !tx_send_en);
    a_level_range: assert property (@(posedge clk) disable iff (reset)
        level <= LVL_FULL);
    a_flags_match: assert property (@(posedge clk) disable iff (reset)
        (full == (level == LVL_FULL)) && (empty == (level == '0)));
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef UART_TX_FEED_GAP_EN
    localparam int GAP = 16;
`else
    localparam int GAP = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full, empty, wr_overflow, tx_send_en, tx_done, feeder_busy;
    logic [ADDR_W:0]   level;
    logic [7:0]        tx_data_byte;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .wr_overflow(wr_overflow),
        .tx_data_byte(tx_data_byte), .tx_send_en(tx_send_en), .tx_done(tx_done),
        .feeder_busy(feeder_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: bytes waiting, one byte launching, one in flight, gap countdown.
    logic [7:0] q[$];
    logic [7:0] sent_log[$];
    bit         m_launch, m_inflight, m_ovf;
    int         m_gap;
    logic [7:0] m_byte;
    int         n_overlap;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       dn;
        logic       s;
        logic [7:0] b;
        logic [4:0] lv;
        logic       f, e, o, busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_launch = 0; m_inflight = 0; m_ovf = 0; m_gap = 0; m_byte = 8'h00;
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic dn);
        bit pop, acc;
        wr_en = w; wr_data = d; tx_done = dn;
        pop = !m_launch && !m_inflight && (m_gap == 0) && (q.size() > 0);
        acc = w && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (m_gap > 0) m_gap--;
        if (pop) begin
            m_byte = q.pop_front();
            m_launch = 1;
        end else if (m_launch) begin
            m_launch = 0;
            m_inflight = 1;
        end else if (m_inflight && dn) begin
            m_inflight = 0;
            m_gap = GAP;
        end
        if (acc) q.push_back(d);
        if (acc && pop) n_overlap++;
        m_ovf = w && !acc;
        #1;
        chk("send",  tx_send_en,   m_launch);
        chk("data",  tx_data_byte, m_byte);
        chk("level", level,        q.size());
        chk("full",  full,         q.size() == DEPTH);
        chk("empty", empty,        q.size() == 0);
        chk("ovf",   wr_overflow,  m_ovf);
        chk("busy",  feeder_busy,  m_launch || m_inflight || (m_gap > 0) || (q.size() > 0));
        if (tx_send_en === 1'b1) sent_log.push_back(tx_data_byte);
    endtask

    // Asserts reset mid-cycle and checks the outputs respond before any clock edge.
    task automatic do_reset_async();
        wr_en = 0; wr_data = 0; tx_done = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_full",  full,         0);
        chk("rst_empty", empty,        1);
        chk("rst_level", level,        0);
        chk("rst_ovf",   wr_overflow,  0);
        chk("rst_data",  tx_data_byte, 8'h00);
        chk("rst_send",  tx_send_en,   0);
        chk("rst_busy",  feeder_busy,  0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] exp_log[$];
`ifndef UART_TX_FEED_GAP_EN
        vec_t tbl[10];
`endif
        reset = 1'b1; wr_en = 0; wr_data = 0; tx_done = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset_async();

`ifndef UART_TX_FEED_GAP_EN
        // Inputs applied in cycle i, outputs expected in cycle i+1.
        tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].w, tbl[i].d, tbl[i].dn);
            chk("tbl_send",  tx_send_en,   tbl[i].s);
            chk("tbl_data",  tx_data_byte, tbl[i].b);
            chk("tbl_level", level,        tbl[i].lv);
            chk("tbl_full",  full,         tbl[i].f);
            chk("tbl_empty", empty,        tbl[i].e);
            chk("tbl_ovf",   wr_overflow,  tbl[i].o);
            chk("tbl_busy",  feeder_busy,  tbl[i].busy);
        end
`endif

        // Burst to full, then one dropped write.
        do_reset_async();
        sent_log.delete();
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            if (i == 15) begin
                chk("burst_level15", level, 15);
                chk("burst_notfull", full, 0);
            end
        end
        chk("burst_level16", level, 16);
        chk("burst_full", full, 1);
        tick(1'b1, 8'hAA, 1'b0);
        chk("burst_ovf_pulse", wr_overflow, 1);
        chk("burst_level_hold", level, 16);
        tick(1'b0, 8'h00, 1'b0);
        chk("burst_ovf_single", wr_overflow, 0);
        k = 0;
        while (feeder_busy && k < 800) begin
            tick(1'b0, 8'h00, 1'b1);
            k++;
        end
        chk("burst_drain_idle", feeder_busy, 0);
        chk("burst_count", sent_log.size(), 17);
        for (int i = 0; i < sent_log.size() && i < 17; i++)
            chk("burst_order", sent_log[i], i);

        // Trickle 40 bytes with level kept low; pointers wrap twice.
        do_reset_async();
        sent_log.delete();
        exp_log.delete();
        n_overlap = 0;
        k = 0;
        for (int cyc = 0; cyc < 1000 && (exp_log.size() < 40 || feeder_busy); cyc++) begin
            if (exp_log.size() < 40 && q.size() < 2) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_log.push_back(b);
                tick(1'b1, b, m_inflight);
            end else begin
                tick(1'b0, 8'h00, m_inflight);
            end
        end
        chk("wrap_count", sent_log.size(), 40);
        for (int i = 0; i < sent_log.size() && i < 40; i++)
            chk("wrap_order", sent_log[i], exp_log[i]);
        chk("wrap_overlap_seen", n_overlap > 0, 1);

        // Spurious done in IDLE and in SEND.
        do_reset_async();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("spur_idle_busy", feeder_busy, 0);
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("spur_send_seen", tx_send_en, 1);
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
        chk("spur_still_waiting", feeder_busy, 1);
        tick(1'b0, 8'h00, 1'b1);

        // Reset while a byte is in flight with more queued.
        do_reset_async();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h40 + 8'(i), 1'b0);
        k = 0;
        while (!m_inflight && k < 20) begin
            tick(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("rst_mid_in_flight", m_inflight, 1);
        do_reset_async();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            chk("rst_after_nosend", tx_send_en, 0);
        end
        tick(1'b1, 8'h99, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("rst_after_send", tx_send_en, 1);
        chk("rst_after_data", tx_data_byte, 8'h99);

        // Done-to-next-send latency with a second byte waiting.
        do_reset_async();
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        k = 0;
        while (!m_inflight && k < 20) begin
            tick(1'b0, 8'h00, 1'b0);
            k++;
        end
        tick(1'b0, 8'h00, 1'b1);
        k = 1;
        while (tx_send_en !== 1'b1 && k < 40) begin
            tick(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("done_to_send_latency", k, GAP + 2);
        chk("second_byte", tx_data_byte, 8'h22);

        // Randomized traffic with spurious and real done pulses.
        do_reset_async();
        for (int i = 0; i < 1500; i++)
            tick(($urandom % 100) < 45, 8'($urandom), ($urandom % 100) < 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
